// File: rtl/hf14a_reader_sched_pkg.sv
// Shared constants for the ISO14443-A reader scheduler: HF datapath mode codes and FSM states.
package hf14a_pkg;

  localparam logic [2:0] SNIFFER       = 3'b000;
  localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
  localparam logic [2:0] TAGSIM_MOD    = 3'b010;
  localparam logic [2:0] READER_LISTEN = 3'b011;
  localparam logic [2:0] READER_MOD    = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    TX,
    GUARD,
    LISTEN,
    RESP
  } state_e;

endpackage

// File: rtl/hf14a_reader_sched_bit_timer.sv
// Loadable bit-period down-counter; decrements on bit_strobe when enabled, saturates at zero.
module hf14a_bit_timer #(
  parameter int TO_W = 12
) (
  input  logic            osc_clk,
  input  logic            rst_n,
  input  logic            bit_strobe,
  input  logic            dec_en,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  output logic [TO_W-1:0] cnt,
  output logic            zero
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (bit_strobe && dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(negedge osc_clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hf14a_reader_sched.sv
// ISO14443-A reader exchange sequencer: TX -> guard -> listen -> response -> done/timeout.
// Optional statistics ports are compiled in with HF14A_SCHED_STATS_EN.
module hf14a_reader_sched
  import hf14a_pkg::*;
#(
  parameter logic [2:0] IDLE_MODE     = 3'b011,
  parameter int         EOF_IDLE_BITS = 2,
  parameter int         TO_W          = 12
) (
  input  logic            osc_clk,
  input  logic            rst_n,
  input  logic            bit_strobe,
  input  logic            curbit,
  input  logic            start,
  input  logic            abort,
  input  logic [8:0]      tx_bits,
  input  logic [7:0]      fdt_bits,
  input  logic [TO_W-1:0] timeout_bits,
  output logic [2:0]      mod_type,
  output logic            busy,
  output logic            rx_window,
  output logic            done,
  output logic            timeout
`ifdef HF14A_SCHED_STATS_EN
  ,
  output logic [9:0]      rx_bit_cnt,
  output logic [7:0]      resp_cnt
`endif
);

  state_e          state_q, state_d;
  logic [8:0]      tx_q, tx_d;
  logic [7:0]      fdt_q, fdt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [2:0]      mod_type_q, mod_type_d;
  logic            busy_q, busy_d;
  logic            rx_window_q, rx_window_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;

  logic            tmr_load, tmr_dec_en, tmr_zero, tmr_last;
  logic [TO_W-1:0] tmr_val, tmr_cnt;

  hf14a_bit_timer #(.TO_W(TO_W)) u_timer (
    .osc_clk    (osc_clk),
    .rst_n      (rst_n),
    .bit_strobe (bit_strobe),
    .dec_en     (tmr_dec_en),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .cnt        (tmr_cnt),
    .zero       (tmr_zero)
  );

  // This strobe takes the timer to zero (or it already sits there).
  assign tmr_last = (tmr_cnt <= TO_W'(1));

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    fdt_d      = fdt_q;
    to_d       = to_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec_en = 1'b1;
    tmr_val    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SYNC;
          tx_d    = tx_bits;
          fdt_d   = fdt_bits;
          to_d    = timeout_bits;
        end
      end
      SYNC: begin
        if (bit_strobe) state_d = (tx_q == '0) ? GUARD : TX;
      end
      TX: begin
        if (bit_strobe && tmr_last) state_d = GUARD;
      end
      GUARD: begin
        if (tmr_zero || (bit_strobe && tmr_last)) state_d = LISTEN;
      end
      LISTEN: begin
        tmr_dec_en = (to_q != '0);
        if (bit_strobe) begin
          if (curbit) begin
            state_d = RESP;
          end else if ((to_q != '0) && tmr_last) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end
        end
      end
      RESP: begin
        // The timer counts remaining idle bits; a '1' bit rearms it.
        tmr_dec_en = !curbit;
        if (bit_strobe) begin
          if (curbit) begin
            tmr_load = 1'b1;
          end else if (tmr_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = IDLE;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end

    if (state_d != state_q) tmr_load = 1'b1;

    case (state_d)
      TX:      tmr_val = TO_W'(tx_q);
      GUARD:   tmr_val = TO_W'(fdt_q);
      LISTEN:  tmr_val = to_q;
      RESP:    tmr_val = TO_W'(EOF_IDLE_BITS);
      default: tmr_val = '0;
    endcase

    mod_type_d  = (state_d == TX) ? READER_MOD : IDLE_MODE;
    busy_d      = (state_d != IDLE);
    rx_window_d = (state_d == LISTEN) || (state_d == RESP);
  end

  always_ff @(negedge osc_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      fdt_q       <= '0;
      to_q        <= '0;
      mod_type_q  <= IDLE_MODE;
      busy_q      <= 1'b0;
      rx_window_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      fdt_q       <= fdt_d;
      to_q        <= to_d;
      mod_type_q  <= mod_type_d;
      busy_q      <= busy_d;
      rx_window_q <= rx_window_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mod_type  = mod_type_q;
  assign busy      = busy_q;
  assign rx_window = rx_window_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

`ifdef HF14A_SCHED_STATS_EN
  logic [9:0] rx_bit_cnt_q, rx_bit_cnt_d;
  logic [7:0] resp_cnt_q, resp_cnt_d;

  always_comb begin
    rx_bit_cnt_d = rx_bit_cnt_q;
    resp_cnt_d   = resp_cnt_q;
    if ((state_d == SYNC) && (state_q != SYNC)) begin
      rx_bit_cnt_d = '0;
    end else if ((state_q == RESP) && bit_strobe) begin
      rx_bit_cnt_d = rx_bit_cnt_q + 1'b1;
    end
    if (done_d) resp_cnt_d = resp_cnt_q + 1'b1;
  end

  always_ff @(negedge osc_clk) begin
    if (!rst_n) begin
      rx_bit_cnt_q <= '0;
      resp_cnt_q   <= '0;
    end else begin
      rx_bit_cnt_q <= rx_bit_cnt_d;
      resp_cnt_q   <= resp_cnt_d;
    end
  end

  assign rx_bit_cnt = rx_bit_cnt_q;
  assign resp_cnt   = resp_cnt_q;
`endif

endmodule
